m_bpred_btb: RTL
================

// Module: m_bpred_btb
// PURPOSE
//  Parametrised branch predictor for the pipelined RV32I core: a direct-mapped
//  branch target buffer (BTB) with 2-bit saturating counters per entry.
//  The IF stage queries it with the fetch PC to get next-PC in the same cycle.
//  The EX stage updates it with resolved branch outcomes. Counts lookups and
//  mispredicts for performance readout.
// PARAMETERS
//  XLEN     32  data/PC width
//  ENTRIES  16  BTB entries; power of two, >=2; IDX_W = $clog2(ENTRIES)
//  TAG_W    8   stored PC tag bits; IDX_W+TAG_W+2 <= XLEN
//  CNT_W    16  width of performance counters
// PORTS
//  w_clk         in   1      clock, all state updates on rising edge
//  w_rst_n       in   1      asynchronous, active-low reset
//  w_pc          in   XLEN   fetch PC (IF stage), lookup key
//  w_lk_en       in   1      lookup valid (fetch not stalled)
//  w_hit         out  1      w_pc matches a valid entry
//  w_pred_taken  out  1      hit && counter[1]
//  w_npc         out  XLEN   predicted next PC: target if taken, else w_pc+4
//  w_upd_en      in   1      resolved conditional branch in EX this cycle
//  w_upd_pc      in   XLEN   PC of resolved branch
//  w_upd_taken   in   1      actual outcome
//  w_upd_tgt     in   XLEN   actual branch target
//  w_upd_miss    in   1      core detected a mispredict (pipeline flush)
//  r_lookups     out  CNT_W  count of cycles with w_lk_en=1
//  r_mispreds    out  CNT_W  count of cycles with w_upd_en && w_upd_miss
// BEHAVIOUR
//  Indexing: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
//  Per entry: valid(1), tag(TAG_W), target(XLEN), ctr(2).
//  Lookup is combinational from stored state; no latency:
//   w_hit = valid[idx] && tag[idx]==tag(w_pc); w_pred_taken = w_hit && ctr[1].
//   w_npc = w_pred_taken ? target[idx] : w_pc+4 (mod 2^XLEN; wraps silently).
//  Update (rising edge, w_upd_en=1), using idx/tag of w_upd_pc:
//   hit:  ctr = taken ? min(ctr+1,3) : max(ctr-1,0); target=w_upd_tgt if taken.
//   miss, taken:     allocate/overwrite: valid=1, tag, target, ctr=2'b10.
//   miss, not taken: no change (no allocation).
//  Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturate
//   at 00 and 11, never wrap.
//  Same-cycle lookup and update to same index: lookup sees pre-update state;
//   new state visible from the next cycle (no bypass).
//  Perf counters: saturate at all-ones, no wrap. r_lookups increments when
//   w_lk_en=1; r_mispreds when w_upd_en && w_upd_miss; w_upd_miss ignored
//   when w_upd_en=0.
//  Reset (w_rst_n=0, async): all valid=0, all ctr=2'b01, targets/tags=0,
//   r_lookups=r_mispreds=0. Outputs: w_hit=0, w_pred_taken=0, w_npc=w_pc+4.
//   Reset mid-operation discards any in-flight update that edge; state is
//   held at reset values while w_rst_n=0.
//  No X on outputs after reset, whatever the inputs.
// TESTING
//  1 Reset: w_rst_n=0 with w_pc=8 -> w_hit=0, w_npc=12, counters 0.
//  2 Loop bne at pc=12 to 8: upd(pc=12,taken,tgt=8) -> next cycle lookup 12
//    gives hit=1, pred_taken=1, npc=8; 2 more taken -> ctr=11, stays 11.
//  3 Loop exit: from ctr=11, one not-taken -> ctr=10, still predicts 8;
//    second not-taken -> 01, npc=16; further not-taken saturates at 00.
//  4 Alias: ENTRIES=16, upd taken at pc=0x0C then pc=0x4C (same idx, diff
//    tag) -> lookup 0x0C misses (npc=0x10), 0x4C hits (npc=tgt).
//  5 Same-cycle: lookup and first taken update to pc=12 in one cycle ->
//    that cycle hit=0, npc=16; next cycle hit=1, npc=8.
//  6 Counters: 5 lookups + 2 upd with w_upd_miss=1 -> r_lookups=5,
//    r_mispreds=2; CNT_W=4, 20 lookups -> r_lookups=15; async reset -> 0.

Source files
------------

// File: rtl/m_bpred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is purely combinational from stored state; updates land on the
// rising edge, so a same-cycle lookup never sees the update (no bypass).
module m_bpred_btb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic [XLEN-1:0]  w_pc,
    input  logic             w_lk_en,
    output logic             w_hit,
    output logic             w_pred_taken,
    output logic [XLEN-1:0]  w_npc,
    input  logic             w_upd_en,
    input  logic [XLEN-1:0]  w_upd_pc,
    input  logic             w_upd_taken,
    input  logic [XLEN-1:0]  w_upd_tgt,
    input  logic             w_upd_miss,
    output logic [CNT_W-1:0] r_lookups,
    output logic [CNT_W-1:0] r_mispreds
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [CNT_W-1:0] lookups_q;
    logic [CNT_W-1:0] mispreds_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_we;
    logic [1:0]       upd_ctr;
    logic [1:0]       ctr_d;

    // Only the index/tag bits of the PCs matter; the rest are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{w_pc, w_upd_pc};

    assign lk_idx  = w_pc[IDX_W+1:2];
    assign lk_tag  = w_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = w_upd_pc[IDX_W+1:2];
    assign upd_tag = w_upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Combinational lookup: hit, direction and next fetch PC.
    always_comb begin
        w_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        w_pred_taken = w_hit && ctr_q[lk_idx][1];
        w_npc        = w_pred_taken ? tgt_q[lk_idx] : (w_pc + XLEN'(4));
    end

    // Update decode: train on a hit, allocate only on a taken miss.
    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_we  = w_upd_en && (upd_hit || w_upd_taken);
        upd_ctr = ctr_q[upd_idx];
        if (!upd_hit) begin
            ctr_d = 2'b10;
        end else if (w_upd_taken) begin
            ctr_d = (upd_ctr == 2'b11) ? upd_ctr : upd_ctr + 2'd1;
        end else begin
            ctr_d = (upd_ctr == 2'b00) ? upd_ctr : upd_ctr - 2'd1;
        end
    end

    // BTB storage: reset to empty with weak-not-taken counters.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_we) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            ctr_q[upd_idx]   <= ctr_d;
            if (w_upd_taken) begin
                tgt_q[upd_idx] <= w_upd_tgt;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            lookups_q  <= '0;
            mispreds_q <= '0;
        end else begin
            if (w_lk_en && (lookups_q != '1)) begin
                lookups_q <= lookups_q + CNT_W'(1);
            end
            if (w_upd_en && w_upd_miss && (mispreds_q != '1)) begin
                mispreds_q <= mispreds_q + CNT_W'(1);
            end
        end
    end

    assign r_lookups  = lookups_q;
    assign r_mispreds = mispreds_q;

endmodule
